// File: rtl/if_prefetch_buf.sv
`default_nettype none
// ============================================================================
//  Module   : if_prefetch_buf
//  Purpose  : Instruction-fetch stage with a DEPTH-entry prefetch FIFO.
//             Owns the PC, issues sequential reads to a 1-cycle-latency
//             synchronous inst SRAM, buffers {pc, inst} pairs and hands them
//             to decode over a valid/allow_in handshake. A downstream
//             redirect flushes everything and restarts fetch at the target.
//  Revision : 1.0  initial release
// ============================================================================
module if_prefetch_buf #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int          DEPTH    = 4,              // power of two, >= 2
    parameter int          CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,

    // inst SRAM (read-only use)
    output logic             inst_sram_en,
    output logic             inst_sram_we,
    output logic [31:0]      inst_sram_addr,
    output logic [31:0]      inst_sram_wdata,
    input  logic [31:0]      inst_sram_rdata,

    // redirect from downstream
    input  logic             br_taken,
    input  logic [31:0]      br_target,

    // decode handshake
    input  logic             ds_allow_in,
    output logic             fs_to_ds_valid,
    output logic [31:0]      fs_pc,
    output logic [31:0]      fs_inst,
    output logic [CNT_W-1:0] fs_count
);

    localparam int                 PTR_W       = $clog2(DEPTH);
    localparam logic [CNT_W:0]     C_DEPTH_EXT = DEPTH[CNT_W:0];
    localparam logic [CNT_W-1:0]   C_DEPTH_CNT = DEPTH[CNT_W-1:0];
    localparam logic [PTR_W-1:0]   C_PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   C_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_pc_q,   req_pc_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic             inflight_q, inflight_d;
    logic [63:0]      mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [31:0]  tgt_pc;
    logic         pop;
    logic         push;
    logic         room_ok;
    logic [CNT_W:0] occ_after;

    // Low target bits are discarded: fetch is always word aligned.
    assign tgt_pc = {br_target[31:2], 2'b00};

    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^br_target[1:0];

    // Handshake, push/pop qualification and the issue decision.
    always_comb begin
        fs_to_ds_valid = resetn & (count_q != '0);
        // A redirect kills both the head hand-off and the returning data.
        pop  = fs_to_ds_valid & ds_allow_in & ~br_taken;
        push = inflight_q & ~br_taken;
        // Occupancy once this cycle's pop retires and the outstanding read
        // lands; a new read may only go out if it will still have a slot.
        occ_after = {1'b0, count_q}
                  - {{CNT_W{1'b0}}, pop}
                  + {{CNT_W{1'b0}}, inflight_q};
        room_ok   = (occ_after < C_DEPTH_EXT);

        inst_sram_en    = resetn & (br_taken | room_ok);
        inst_sram_we    = 1'b0;
        inst_sram_wdata = 32'h0;
        if (!resetn) begin
            inst_sram_addr = RESET_PC;
        end else if (br_taken) begin
            inst_sram_addr = tgt_pc;
        end else begin
            inst_sram_addr = fetch_pc_q;
        end

        fs_pc    = mem_q[rd_ptr_q][63:32];
        fs_inst  = mem_q[rd_ptr_q][31:0];
        fs_count = resetn ? count_q : '0;
    end

    // Next-state for PC, pointers, occupancy and the in-flight tracker.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        inflight_d = inst_sram_en;

        if (br_taken) begin
            // Flush: drop all buffered entries by snapping rd onto wr, and
            // restart at the target in this very cycle.
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            req_pc_d   = tgt_pc;
            fetch_pc_d = tgt_pc + 32'd4;
            inflight_d = 1'b1;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + C_PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + C_PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + C_CNT_ONE;
                2'b01:   count_d = count_q - C_CNT_ONE;
                default: count_d = count_q;
            endcase
            if (inst_sram_en) begin
                req_pc_d   = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

    // FIFO storage: capture the returning read together with its address.
    always_ff @(posedge clk) begin
        if (resetn && push) begin
            mem_q[wr_ptr_q] <= {req_pc_q, inst_sram_rdata};
        end
    end

    // The issue rule reserves a slot for every outstanding read, so a push
    // into a full buffer means that reservation logic is broken.
    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(push && (count_q == C_DEPTH_CNT)));

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_prefetch_buf
//  Purpose  : Directed self-checking bench for if_prefetch_buf with a
//             1-cycle synchronous SRAM model returning addr ^ A5A5A5A5.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_prefetch_buf;

    localparam logic [31:0] C_KEY = 32'hA5A5A5A5;
    localparam logic [31:0] C_RST = 32'h1c000000;

    logic        clk;
    logic        resetn;
    logic        inst_sram_en;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        br_taken;
    logic [31:0] br_target;
    logic        ds_allow_in;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic [2:0]  fs_count;

    int n_tests;
    int n_fail;

    if_prefetch_buf #(
        .RESET_PC (32'h1c000000),
        .DEPTH    (4)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .ds_allow_in     (ds_allow_in),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_pc           (fs_pc),
        .fs_inst         (fs_inst),
        .fs_count        (fs_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: data for a request appears the following cycle.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= inst_sram_addr ^ C_KEY;
    end

    // Reset held for two cycles; returns in cycle 0 after release.
    task automatic do_reset(input logic allow);
        @(negedge clk);
        resetn = 1'b0; br_taken = 1'b0; br_target = 32'h0; ds_allow_in = allow;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        resetn = 1'b0; br_taken = 1'b0; br_target = 32'h0; ds_allow_in = 1'b1;
        @(negedge clk); #1;
        n_tests++; if (inst_sram_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", inst_sram_en); end
        n_tests++; if (fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", fs_to_ds_valid); end
        n_tests++; if (fs_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fs_count); end
        n_tests++; if (inst_sram_addr !== C_RST) begin n_fail++; $display("FAIL reset_addr: got %h want %h", inst_sram_addr, C_RST); end
        n_tests++; if (inst_sram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", inst_sram_we); end
        n_tests++; if (inst_sram_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", inst_sram_wdata); end
    endtask

    task automatic test_stream;
        logic [31:0] exp_pc;
        do_reset(1'b1);
        #1;
        n_tests++; if (inst_sram_en !== 1'b1) begin n_fail++; $display("FAIL stream_c0_en: got %b want 1", inst_sram_en); end
        n_tests++; if (inst_sram_addr !== C_RST) begin n_fail++; $display("FAIL stream_c0_addr: got %h want %h", inst_sram_addr, C_RST); end
        n_tests++; if (fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL stream_c0_valid: got %b want 0", fs_to_ds_valid); end
        @(negedge clk); #1;
        n_tests++; if (fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL stream_c1_valid: got %b want 0", fs_to_ds_valid); end
        n_tests++; if (inst_sram_addr !== 32'h1c000004) begin n_fail++; $display("FAIL stream_c1_addr: got %h want 1c000004", inst_sram_addr); end
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            exp_pc = C_RST + 32'(4 * k);
            #1;
            n_tests++; if (fs_to_ds_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", k, fs_to_ds_valid); end
            n_tests++; if (fs_pc !== exp_pc) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", k, fs_pc, exp_pc); end
            n_tests++; if (fs_inst !== (exp_pc ^ C_KEY)) begin n_fail++; $display("FAIL stream_inst[%0d]: got %h want %h", k, fs_inst, exp_pc ^ C_KEY); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        int issued;
        issued = 0;
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            #1;
            if (inst_sram_en === 1'b1) issued++;
            @(negedge clk);
        end
        #1;
        n_tests++; if (issued !== 4) begin n_fail++; $display("FAIL bp_issued: got %0d want 4", issued); end
        n_tests++; if (inst_sram_en !== 1'b0) begin n_fail++; $display("FAIL bp_en: got %b want 0", inst_sram_en); end
        n_tests++; if (fs_count !== 3'd4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", fs_count); end
        n_tests++; if (fs_pc !== C_RST) begin n_fail++; $display("FAIL bp_pc: got %h want %h", fs_pc, C_RST); end
        n_tests++; if (inst_sram_addr !== 32'h1c000010) begin n_fail++; $display("FAIL bp_hold_addr: got %h want 1c000010", inst_sram_addr); end
    endtask

    // Continues from the full buffer left by test_backpressure.
    task automatic test_wrap;
        logic [31:0] exp_pc;
        logic [2:0]  exp_cnt;
        @(negedge clk);
        ds_allow_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_pc  = C_RST + 32'(4 * k);
            exp_cnt = (k == 0) ? 3'd4 : 3'd3;
            #1;
            n_tests++; if (fs_count !== exp_cnt) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d want %0d", k, fs_count, exp_cnt); end
            n_tests++; if (fs_to_ds_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid[%0d]: got %b want 1", k, fs_to_ds_valid); end
            n_tests++; if (fs_pc !== exp_pc) begin n_fail++; $display("FAIL wrap_pc[%0d]: got %h want %h", k, fs_pc, exp_pc); end
            n_tests++; if (fs_inst !== (exp_pc ^ C_KEY)) begin n_fail++; $display("FAIL wrap_inst[%0d]: got %h want %h", k, fs_inst, exp_pc ^ C_KEY); end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect;
        do_reset(1'b0);
        repeat (4) @(negedge clk);
        br_taken = 1'b1; br_target = 32'h1c000103;
        #1;
        n_tests++; if (fs_count !== 3'd3) begin n_fail++; $display("FAIL br_pre_count: got %0d want 3", fs_count); end
        n_tests++; if (inst_sram_en !== 1'b1) begin n_fail++; $display("FAIL br_en: got %b want 1", inst_sram_en); end
        n_tests++; if (inst_sram_addr !== 32'h1c000100) begin n_fail++; $display("FAIL br_addr: got %h want 1c000100", inst_sram_addr); end
        @(negedge clk);
        br_taken = 1'b0; br_target = 32'h0; ds_allow_in = 1'b1;
        #1;
        n_tests++; if (fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL br_t1_valid: got %b want 0", fs_to_ds_valid); end
        n_tests++; if (fs_count !== 3'd0) begin n_fail++; $display("FAIL br_t1_count: got %0d want 0", fs_count); end
        n_tests++; if (inst_sram_addr !== 32'h1c000104) begin n_fail++; $display("FAIL br_t1_addr: got %h want 1c000104", inst_sram_addr); end
        @(negedge clk); #1;
        n_tests++; if (fs_to_ds_valid !== 1'b1) begin n_fail++; $display("FAIL br_t2_valid: got %b want 1", fs_to_ds_valid); end
        n_tests++; if (fs_pc !== 32'h1c000100) begin n_fail++; $display("FAIL br_t2_pc: got %h want 1c000100", fs_pc); end
        n_tests++; if (fs_inst !== (32'h1c000100 ^ C_KEY)) begin n_fail++; $display("FAIL br_t2_inst: got %h want %h", fs_inst, 32'h1c000100 ^ C_KEY); end
        n_tests++; if (fs_count !== 3'd1) begin n_fail++; $display("FAIL br_t2_count: got %0d want 1", fs_count); end
        @(negedge clk); #1;
        n_tests++; if (fs_pc !== 32'h1c000104) begin n_fail++; $display("FAIL br_t3_pc: got %h want 1c000104", fs_pc); end
    endtask

    task automatic test_reset_midstream;
        do_reset(1'b1);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        n_tests++; if (inst_sram_en !== 1'b0) begin n_fail++; $display("FAIL mrst_en: got %b want 0", inst_sram_en); end
        n_tests++; if (fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %b want 0", fs_to_ds_valid); end
        n_tests++; if (inst_sram_addr !== C_RST) begin n_fail++; $display("FAIL mrst_addr: got %h want %h", inst_sram_addr, C_RST); end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        n_tests++; if (fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_c0_valid: got %b want 0", fs_to_ds_valid); end
        n_tests++; if (fs_count !== 3'd0) begin n_fail++; $display("FAIL mrst_c0_count: got %0d want 0", fs_count); end
        n_tests++; if (inst_sram_addr !== C_RST) begin n_fail++; $display("FAIL mrst_c0_addr: got %h want %h", inst_sram_addr, C_RST); end
        @(negedge clk); #1;
        n_tests++; if (fs_count !== 3'd0) begin n_fail++; $display("FAIL mrst_c1_count: got %0d want 0", fs_count); end
        @(negedge clk); #1;
        n_tests++; if (fs_pc !== C_RST) begin n_fail++; $display("FAIL mrst_c2_pc: got %h want %h", fs_pc, C_RST); end
        n_tests++; if (fs_inst !== (C_RST ^ C_KEY)) begin n_fail++; $display("FAIL mrst_c2_inst: got %h want %h", fs_inst, C_RST ^ C_KEY); end
    endtask

    task automatic test_addr_wrap;
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        br_taken = 1'b1; br_target = 32'hFFFFFFFF;
        #1;
        n_tests++; if (inst_sram_addr !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL aw_br_addr: got %h want fffffffc", inst_sram_addr); end
        @(negedge clk);
        br_taken = 1'b0; br_target = 32'h0;
        #1;
        n_tests++; if (inst_sram_en !== 1'b1) begin n_fail++; $display("FAIL aw_en: got %b want 1", inst_sram_en); end
        n_tests++; if (inst_sram_addr !== 32'h00000000) begin n_fail++; $display("FAIL aw_next_addr: got %h want 00000000", inst_sram_addr); end
        @(negedge clk); #1;
        n_tests++; if (fs_pc !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL aw_pc0: got %h want fffffffc", fs_pc); end
        n_tests++; if (fs_inst !== 32'h5A5A5A59) begin n_fail++; $display("FAIL aw_inst0: got %h want 5a5a5a59", fs_inst); end
        @(negedge clk); #1;
        n_tests++; if (fs_pc !== 32'h00000000) begin n_fail++; $display("FAIL aw_pc1: got %h want 00000000", fs_pc); end
        n_tests++; if (fs_inst !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL aw_inst1: got %h want a5a5a5a5", fs_inst); end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        resetn = 1'b0; br_taken = 1'b0; br_target = 32'h0; ds_allow_in = 1'b0;
        inst_sram_rdata = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_wrap();
        test_redirect();
        test_reset_midstream();
        test_addr_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
